// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the pins, deframes 11-bit frames with
// start/stop/odd-parity checks and a mid-frame timeout, and queues good bytes in a FIFO.
module ps2_rx_fifo #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 50000
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_ps2_clk,
  input  logic              i_ps2_data,
  input  logic              i_nextdata_n,
  output logic [7:0]        o_data,
  output logic              o_ready,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_count,
  output logic              o_parity_err,
  output logic              o_frame_err
);

  // state  | meaning
  // S_IDLE | bitcnt=0, waiting for the start-bit falling edge
  // S_RECV | bitcnt 1..10, shifting frame bits in LSB first

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  state_t                 r_state;
  logic [3:0]             r_bitcnt;
  logic [9:0]             r_shift;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_parity_err;
  logic                   r_frame_err;

  logic                   w_last;
  logic [7:0]             w_byte;
  logic                   w_frame_bad;
  logic                   w_par_bad;
  logic                   w_push;

  logic [7:0]             r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wptr;
  logic [ADDR_W-1:0]      r_rptr;
  logic [ADDR_W:0]        r_count;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wr;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  // Flops reset to 1 so a reset never manufactures a falling edge on an idle bus
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // After ten samples r_shift holds {parity, data[7:0], start}; the stop bit is the live sample
  assign w_last      = (r_state == S_RECV) && w_fall && (r_bitcnt == 4'd10);
  assign w_byte      = r_shift[8:1];
  assign w_frame_bad = r_shift[0] | ~w_data_s;
  assign w_par_bad   = ~(^{w_byte, r_shift[9]});
  assign w_push      = w_last & ~w_frame_bad & ~w_par_bad;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= 4'd0;
      r_shift      <= 10'd0;
      r_tmo        <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_fall) begin
            r_shift  <= {w_data_s, r_shift[9:1]};
            r_bitcnt <= 4'd1;
            r_state  <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_tmo <= '0;
            if (r_bitcnt == 4'd10) begin
              r_bitcnt <= 4'd0;
              r_state  <= S_IDLE;
              if (w_frame_bad)
                r_frame_err <= 1'b1;
              else if (w_par_bad)
                r_parity_err <= 1'b1;
            end else begin
              r_shift  <= {w_data_s, r_shift[9:1]};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_tmo       <= '0;
            r_bitcnt    <= 4'd0;
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_bitcnt <= 4'd0;
        end
      endcase
    end
  end

  // A pop on the same edge as a push into a full FIFO frees the slot being written
  assign w_pop  = ~i_nextdata_n & (r_count != '0);
  assign w_full = (r_count == FULL_CNT);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)
        r_overflow <= 1'b0;
      else if (w_push && w_full)
        r_overflow <= 1'b1;
    end
  end

  assign o_data       = r_mem[r_rptr];
  assign o_ready      = (r_count != '0);
  assign o_count      = r_count;
  assign o_overflow   = r_overflow;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: bit-banged PS/2 frames, expected bytes queued
// as frames are sent and compared as they are popped.
module tb_ps2_rx_fifo;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int SYNC   = 3;
  localparam int TMO    = 500;
  localparam int HALF   = 40;

  logic              clk = 1'b0;
  logic              clr;
  logic              ps2_clk;
  logic              ps2_data;
  logic              nextdata_n;
  logic [7:0]        o_data;
  logic              o_ready;
  logic              o_overflow;
  logic [ADDR_W:0]   o_count;
  logic              o_parity_err;
  logic              o_frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_clr        (clr),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .i_nextdata_n (nextdata_n),
    .o_data       (o_data),
    .o_ready      (o_ready),
    .o_overflow   (o_overflow),
    .o_count      (o_count),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_perr   = 0;
  int         n_ferr   = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Cycles each error output is high; one-cycle pulses make this the pulse count
  always @(negedge clk) begin
    if (!clr) begin
      if (o_parity_err) n_perr++;
      if (o_frame_err)  n_ferr++;
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(o_count), 32'(exp_q.size()));
    chk({tag, "_ready"}, 32'(o_ready), 32'(exp_q.size() != 0));
    chk({tag, "_ovf"},   32'(o_overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) chk({tag, "_head"}, 32'(o_data), 32'(exp_q[0]));
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_data"},  32'(o_data), 32'(exp_q[0]));
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    void'(exp_q.pop_front());
    exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  // Falls are seen by the receiver SYNC+1 edges after ps2_clk drops; pop_here lands
  // the pop on exactly that edge.
  task automatic send_bit(input logic b, input logic pop_here);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_here) begin
      repeat (SYNC) @(negedge clk);
      chk("stop_pop_head", 32'(o_data), 32'(exp_q[0]));
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      void'(exp_q.pop_front());
      exp_ovf = 1'b0;
      repeat (HALF - SYNC - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic start_b,
                            input logic stop_b, input logic pop_at_stop);
    logic par;
    par = par_ok ? ~(^b) : ^b;
    send_bit(start_b, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop_b, pop_at_stop);
    @(negedge clk);
    ps2_data = 1'b1;
    if (!start_b && stop_b && par_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int p0;
    int f0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    clr        = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_state("reset");
    chk("reset_perr", o_parity_err, 1'b0);
    chk("reset_ferr", o_frame_err, 1'b0);

    // Reset in the middle of a frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("midreset");
    chk("midreset_head", 32'(o_data), 32'h1C);
    chk("midreset_perr_cnt", n_perr, 0);
    chk("midreset_ferr_cnt", n_ferr, 0);

    // Ordering
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("three");
    for (int i = 0; i < 3; i++) pop_one("order_pop");
    check_state("order_drained");

    // Pointer wrap with interleaved pops
    for (int i = 0; i < 10; i++) begin
      send_frame(8'(8'h21 + i * 13), 1'b1, 1'b0, 1'b1, 1'b0);
      if (i % 3 == 2) begin
        pop_one("wrap_pop");
        pop_one("wrap_pop");
      end
    end
    check_state("wrap_mid");
    while (exp_q.size() != 0) pop_one("wrap_drain");
    check_state("wrap_drained");

    // Fill and overflow
    for (int i = 0; i < 9; i++) send_frame(8'(8'h40 + i), 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("full");
    chk("full_count_8", 32'(o_count), 32'd8);
    chk("full_ovf_set", 32'(o_overflow), 32'd1);
    pop_one("full_pop");
    check_state("after_pop");
    chk("after_pop_head_byte2", 32'(o_data), 32'h41);
    send_frame(8'h50, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("refull");
    send_frame(8'h51, 1'b1, 1'b0, 1'b1, 1'b1);
    check_state("full_pop_push");
    while (exp_q.size() != 0) pop_one("full_drain");
    check_state("full_drained");

    // Parity error
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("parity_pulse", n_perr - p0, 1);
    chk("parity_no_ferr", n_ferr - f0, 0);
    check_state("parity");

    // Framing errors
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stop0_ferr", n_ferr - f0, 1);
    chk("stop0_no_perr", n_perr - p0, 0);
    check_state("stop0");
    f0 = n_ferr;
    send_frame(8'h66, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("start1_ferr", n_ferr - f0, 1);
    check_state("start1");

    // Timeout after a partial frame
    p0 = n_perr; f0 = n_ferr;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (400) @(negedge clk);
    chk("tmo_not_yet", n_ferr - f0, 0);
    repeat (200) @(negedge clk);
    chk("tmo_ferr_once", n_ferr - f0, 1);
    chk("tmo_no_perr", n_perr - p0, 0);
    check_state("tmo");
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("post_tmo");
    pop_one("post_tmo_pop");
    check_state("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver with a configurable-depth byte FIFO. Next-generation keyboard front end.
- Adds the following over the current keyboard receiver:
  - synchronous active-high reset
  - configurable synchroniser depth
  - odd-parity and framing checks, with bad frames discarded
  - a mid-frame inactivity timeout
  - a FIFO occupancy count
- Sits between the board PS/2 pins and the scan-code consumer (7-segment display or CPU MMIO).

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W entries, all usable.
- SYNC_STAGES, 3, flip-flop stages synchronising ps2_clk and ps2_data (minimum 2).
- TIMEOUT, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  synchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- nextdata_n  in  1  active-low pop request, sampled every clk.
- data  out  8  FIFO head byte; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  a valid byte was dropped because the FIFO was full.
- count  out  ADDR_W+1  number of bytes held, 0..2**ADDR_W.
- parity_err  out  1  one-cycle pulse when a frame fails the odd-parity check.
- frame_err  out  1  one-cycle pulse on bad start bit, bad stop bit or timeout.

Behaviour:
- Clock and reset: one clock (clk); reset clr is synchronous and active-high.
- Reset (clr=1 at a clk edge):
  - pointers, count, bit counter, timeout counter and shift register cleared
  - synchroniser flops set to 1 (idle bus)
  - ready=0, overflow=0, parity_err=0, frame_err=0, count=0, data don't-care
  - reset mid-frame discards the partial frame; no error pulse is generated.
- Edge detection:
  - both PS/2 inputs pass through SYNC_STAGES flops
  - fall = previous synced ps2_clk 1 and current 0
  - on fall, synced ps2_data is sampled.
- Receiver states:
  - IDLE: bitcnt=0, waiting for a fall.
  - RECV: bitcnt 1..10, shifting bits LSB first.
  - Frame format: bit 0 start (must be 0), bits 1-8 data LSB first, bit 9 parity, bit 10 stop (must be 1).
  - On the 11th sample the frame is checked at that same clk edge and bitcnt returns to 0.
- Frame check priority:
  - start=1 or stop=0 -> frame_err pulse, byte discarded.
  - Otherwise, XOR of data and parity = 0 -> parity_err pulse, byte discarded.
  - Otherwise the byte is valid.
- Push: a valid byte is written at wptr on the same edge the stop bit is sampled.
  - ready rises, and count increments, on the following cycle.
- Pop: when nextdata_n=0 and ready=1 at a clk edge, rptr advances by 1.
  - Pop is level-sensitive: one byte per cycle while nextdata_n is held low.
  - Popping while empty is ignored.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, a simultaneous pop frees the slot: the byte is stored and overflow is not set.
- Full (count = 2**ADDR_W) and valid byte arrives with no pop: byte dropped, overflow set.
  - overflow is sticky; it clears on the next successful pop or on clr.
- Pointers are ADDR_W bits and wrap modulo depth; count is tracked separately (or derived with a wrap bit).
- Timeout:
  - the counter increments each cycle while bitcnt != 0 and resets on every fall
  - reaching TIMEOUT forces bitcnt=0 and pulses frame_err once
  - no timeout is active in IDLE.
- Pulse timing: parity_err and frame_err are registered and high for exactly one cycle, the cycle after the detecting edge.
- data = fifo[rptr], combinational from the storage array.

Test Plan:
- Reset behaviour: bench frames use a PS/2 half-period of 40 clk. Assert clr for 3 cycles mid-frame, then send byte 0x1C (parity 0) -> exactly one entry; data=0x1C, ready=1, count=1, no error pulses.
- Ordering and wrap: with ADDR_W=3, send 0x1C, 0xF0 (parity 1), 0x1C, then pop three times with nextdata_n low for 1 cycle each -> data reads 0x1C, 0xF0, 0x1C; ready=0 and count=0 afterwards. Then send 10 more bytes with interleaved pops -> order preserved across the pointer wrap.
- Fill and overflow: send 9 distinct bytes with no pops -> count=8, overflow=1, the 9th byte is lost. Pop once -> overflow=0, count=7, head is byte #2. A further pop issued on the same edge a new stop bit is sampled while full -> count unchanged, overflow stays 0.
- Parity error: send 0x00 with parity 0 -> parity_err pulses for 1 cycle, count unchanged, frame_err=0.
- Framing errors: frame with stop=0 -> frame_err pulse, no push. Frame with start=1 -> frame_err pulse.
- Timeout: TIMEOUT set to 500. Send 5 bits, then hold ps2_clk high for 600 cycles -> frame_err pulses once at cycle 500. A following complete 0xF0 frame is received correctly.
